// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack opcodes, selector codes and the
// stack sequencer state encoding.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_CALL  = 3'd3,
        OP_RET   = 3'd4,
        OP_ENTER = 3'd5,
        OP_LEAVE = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_MEM  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    localparam logic [3:0] SEL_ESP = 4'h2;
    localparam logic [3:0] SEL_IMM = 4'h3;

endpackage

// File: rtl/stack_sequencer.sv
// Stack sequencer: owns eip/ebp/esp and runs PUSH/POP/CALL/RET/ENTER/LEAVE
// as multi-cycle accesses to a single-port data memory.
module stack_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0] STACK_TOP   = 8'hFF,
    parameter logic [7:0] STACK_LIMIT = 8'h80,
    parameter logic [7:0] EIP_RESET   = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [7:0] op_data,
    input  logic       eip_inc,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [3:0] sel_code,
    output logic [7:0] eip,
    output logic [7:0] ebp,
    output logic [7:0] esp,
    output logic [7:0] pop_data,
    output logic       done,
    output logic       err
);

    state_e     state_q;
    op_e        op_q;
    logic [7:0] data_q;
    logic [7:0] eip_q, ebp_q, esp_q, pop_q;
    logic       mem_req_q, mem_we_q;
    logic [7:0] mem_addr_q, mem_wdata_q;
    logic       done_q, err_q;
    logic [3:0] sel_q;

    logic       is_push, overflow, underflow;
    logic [7:0] push_wdata_d;

    // Classify the latched op and evaluate the stack bounds against it.
    always_comb begin
        is_push   = (op_q == OP_PUSH) || (op_q == OP_CALL) || (op_q == OP_ENTER);
        overflow  = is_push && (esp_q == STACK_LIMIT);
        underflow = (((op_q == OP_POP) || (op_q == OP_RET)) && (esp_q == STACK_TOP))
                 || ((op_q == OP_LEAVE) && (ebp_q == STACK_TOP));
    end

    // Data written by the push-type ops: operand, return address or frame pointer.
    always_comb begin
        push_wdata_d = data_q;
        case (op_q)
            OP_CALL:  push_wdata_d = eip_q + 8'd1;
            OP_ENTER: push_wdata_d = ebp_q;
            default:  push_wdata_d = data_q;
        endcase
    end

    // Sequencer FSM with all outputs registered; reset abandons any op in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            data_q      <= 8'h00;
            eip_q       <= EIP_RESET;
            ebp_q       <= STACK_TOP;
            esp_q       <= STACK_TOP;
            pop_q       <= 8'h00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'h00;
            mem_wdata_q <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sel_q       <= SEL_IMM;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        if ((op_e'(op_code) == OP_NOP) || (op_e'(op_code) == OP_RSVD)) begin
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            op_q    <= op_e'(op_code);
                            data_q  <= op_data;
                            sel_q   <= SEL_ESP;
                            state_q <= ST_PREP;
                        end
                    end else if (eip_inc) begin
                        eip_q <= eip_q + 8'd1;
                    end
                end
                ST_PREP: begin
                    if (overflow || underflow) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        sel_q   <= SEL_IMM;
                        state_q <= ST_FIN;
                    end else begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= is_push;
                        if (is_push) begin
                            mem_addr_q  <= esp_q - 8'd1;
                            mem_wdata_q <= push_wdata_d;
                        end else if (op_q == OP_LEAVE) begin
                            // LEAVE collapses the frame first, then pops the saved ebp.
                            esp_q      <= ebp_q;
                            mem_addr_q <= ebp_q;
                        end else begin
                            mem_addr_q <= esp_q;
                        end
                        state_q <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        case (op_q)
                            OP_PUSH:  esp_q <= esp_q - 8'd1;
                            OP_CALL: begin
                                esp_q <= esp_q - 8'd1;
                                eip_q <= data_q;
                            end
                            OP_ENTER: begin
                                esp_q <= esp_q - 8'd1;
                                ebp_q <= esp_q - 8'd1;
                            end
                            OP_POP: begin
                                pop_q <= mem_rdata;
                                esp_q <= esp_q + 8'd1;
                            end
                            OP_RET: begin
                                eip_q <= mem_rdata;
                                esp_q <= esp_q + 8'd1;
                            end
                            OP_LEAVE: begin
                                ebp_q <= mem_rdata;
                                esp_q <= esp_q + 8'd1;
                            end
                            default: ;
                        endcase
                        done_q  <= 1'b1;
                        sel_q   <= SEL_IMM;
                        state_q <= ST_FIN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_ready  = (state_q == ST_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign sel_code  = sel_q;
    assign eip       = eip_q;
    assign ebp       = ebp_q;
    assign esp       = esp_q;
    assign pop_data  = pop_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed testbench for stack_sequencer.
module tb_stack_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [7:0] op_data;
    logic       eip_inc;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [3:0] sel_code;
    logic [7:0] eip;
    logic [7:0] ebp;
    logic [7:0] esp;
    logic [7:0] pop_data;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;

    stack_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_data   (op_data),
        .eip_inc   (eip_inc),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .sel_code  (sel_code),
        .eip       (eip),
        .ebp       (ebp),
        .esp       (esp),
        .pop_data  (pop_data),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Observations from the most recent operation.
    int         o_lat;
    int         o_req;
    logic [7:0] o_addr;
    logic [7:0] o_wd;
    logic       o_we;
    logic       o_stable;
    logic       o_err;
    logic       o_sel;

    // Issue one op from IDLE, service the memory with ack_wait wait cycles,
    // and record what was observed; returns in the IDLE cycle after FIN.
    task automatic run_op(input logic [2:0] code, input logic [7:0] data,
                          input int ack_wait, input logic [7:0] rdata);
        o_lat = -1; o_req = 0; o_addr = 8'h00; o_wd = 8'h00; o_we = 1'b0;
        o_stable = 1'b1; o_err = 1'b0; o_sel = 1'b1;
        op_valid = 1'b1; op_code = code; op_data = data;
        @(negedge clk);
        op_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                o_lat = c;
                o_err = err;
                if (sel_code !== SEL_IMM) o_sel = 1'b0;
                break;
            end
            if (sel_code !== SEL_ESP) o_sel = 1'b0;
            if (mem_req) begin
                if (o_req == 0) begin
                    o_addr = mem_addr; o_wd = mem_wdata; o_we = mem_we;
                end else if (mem_addr !== o_addr || mem_wdata !== o_wd || mem_we !== o_we) begin
                    o_stable = 1'b0;
                end
                o_req++;
                if (o_req > ack_wait) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_op_ready got=%h exp=1", op_ready); end
        checks++; if (eip !== 8'h00) begin failures++; $display("FAIL reset_eip got=%h exp=00", eip); end
        checks++; if (esp !== 8'hFF || ebp !== 8'hFF) begin failures++; $display("FAIL reset_esp_ebp got=%h/%h exp=ff/ff", esp, ebp); end
        checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 18'h0) begin failures++; $display("FAIL reset_mem got=%b%b %h %h exp=00 00 00", mem_req, mem_we, mem_addr, mem_wdata); end
        checks++; if ({done, err, pop_data} !== 10'h0) begin failures++; $display("FAIL reset_done_err_pop got=%b%b %h exp=00 00", done, err, pop_data); end
        checks++; if (sel_code !== 4'h3) begin failures++; $display("FAIL reset_sel got=%h exp=3", sel_code); end
    endtask

    task automatic test_push();
        run_op(OP_PUSH, 8'hA5, 0, 8'h00);
        checks++; if (o_lat !== 3) begin failures++; $display("FAIL push_latency got=%0d exp=3", o_lat); end
        checks++; if ({o_we, o_addr, o_wd} !== {1'b1, 8'hFE, 8'hA5}) begin failures++; $display("FAIL push_mem got=%b %h %h exp=1 fe a5", o_we, o_addr, o_wd); end
        checks++; if (esp !== 8'hFE) begin failures++; $display("FAIL push_esp got=%h exp=fe", esp); end
        checks++; if (o_sel !== 1'b1) begin failures++; $display("FAIL push_sel got=%b exp=1", o_sel); end
        checks++; if (done !== 1'b0 || o_err !== 1'b0) begin failures++; $display("FAIL push_done_pulse got=%b err=%b exp=0 0", done, o_err); end
        run_op(OP_POP, 8'h00, 0, 8'hA5);
        checks++; if (pop_data !== 8'hA5 || esp !== 8'hFF) begin failures++; $display("FAIL pop_fast got=%h esp=%h exp=a5 ff", pop_data, esp); end
    endtask

    task automatic test_pop_wait();
        run_op(OP_PUSH, 8'h11, 0, 8'h00);
        run_op(OP_POP, 8'h00, 3, 8'h11);
        checks++; if (o_req !== 4) begin failures++; $display("FAIL pop_req_cycles got=%0d exp=4", o_req); end
        checks++; if (o_addr !== 8'hFE || o_we !== 1'b0 || o_stable !== 1'b1) begin failures++; $display("FAIL pop_mem got=%h we=%b stable=%b exp=fe 0 1", o_addr, o_we, o_stable); end
        checks++; if (pop_data !== 8'h11 || esp !== 8'hFF) begin failures++; $display("FAIL pop_result got=%h esp=%h exp=11 ff", pop_data, esp); end
        checks++; if (o_lat !== 6) begin failures++; $display("FAIL pop_latency got=%0d exp=6", o_lat); end
    endtask

    task automatic test_call_ret();
        eip_inc = 1'b1;
        repeat (16) @(negedge clk);
        eip_inc = 1'b0;
        checks++; if (eip !== 8'h10) begin failures++; $display("FAIL eip_inc got=%h exp=10", eip); end
        run_op(OP_CALL, 8'h40, 0, 8'h00);
        checks++; if ({o_we, o_addr, o_wd} !== {1'b1, 8'hFE, 8'h11}) begin failures++; $display("FAIL call_mem got=%b %h %h exp=1 fe 11", o_we, o_addr, o_wd); end
        checks++; if (eip !== 8'h40 || esp !== 8'hFE) begin failures++; $display("FAIL call_regs got=%h esp=%h exp=40 fe", eip, esp); end
        run_op(OP_RET, 8'h00, 1, 8'h11);
        checks++; if (o_addr !== 8'hFE || o_we !== 1'b0) begin failures++; $display("FAIL ret_mem got=%h we=%b exp=fe 0", o_addr, o_we); end
        checks++; if (eip !== 8'h11 || esp !== 8'hFF) begin failures++; $display("FAIL ret_regs got=%h esp=%h exp=11 ff", eip, esp); end
    endtask

    task automatic test_enter_leave();
        run_op(OP_ENTER, 8'h00, 0, 8'h00);
        checks++; if ({o_we, o_addr, o_wd} !== {1'b1, 8'hFE, 8'hFF}) begin failures++; $display("FAIL enter_mem got=%b %h %h exp=1 fe ff", o_we, o_addr, o_wd); end
        checks++; if (ebp !== 8'hFE || esp !== 8'hFE) begin failures++; $display("FAIL enter_regs got=%h esp=%h exp=fe fe", ebp, esp); end
        run_op(OP_LEAVE, 8'h00, 0, 8'hFF);
        checks++; if (o_addr !== 8'hFE || o_we !== 1'b0) begin failures++; $display("FAIL leave_mem got=%h we=%b exp=fe 0", o_addr, o_we); end
        checks++; if (ebp !== 8'hFF || esp !== 8'hFF) begin failures++; $display("FAIL leave_regs got=%h esp=%h exp=ff ff", ebp, esp); end
    endtask

    task automatic test_bounds();
        run_op(OP_POP, 8'h00, 0, 8'h55);
        checks++; if (o_lat !== 2 || o_err !== 1'b1 || o_req !== 0) begin failures++; $display("FAIL pop_underflow got=lat%0d err%b req%0d exp=lat2 err1 req0", o_lat, o_err, o_req); end
        checks++; if (esp !== 8'hFF || pop_data !== 8'h11) begin failures++; $display("FAIL pop_underflow_regs got=%h pop=%h exp=ff 11", esp, pop_data); end
        run_op(OP_RET, 8'h00, 0, 8'h55);
        checks++; if (o_err !== 1'b1 || eip !== 8'h11) begin failures++; $display("FAIL ret_underflow got=err%b eip=%h exp=1 11", o_err, eip); end
        run_op(OP_LEAVE, 8'h00, 0, 8'h55);
        checks++; if (o_err !== 1'b1 || o_req !== 0) begin failures++; $display("FAIL leave_underflow got=err%b req%0d exp=1 0", o_err, o_req); end
        for (int i = 0; i < 127; i++) run_op(OP_PUSH, 8'(i), 0, 8'h00);
        checks++; if (esp !== 8'h80 || o_addr !== 8'h80 || o_err !== 1'b0) begin failures++; $display("FAIL fill got=%h addr=%h err=%b exp=80 80 0", esp, o_addr, o_err); end
        run_op(OP_PUSH, 8'h77, 0, 8'h00);
        checks++; if (o_lat !== 2 || o_err !== 1'b1 || o_req !== 0 || esp !== 8'h80) begin failures++; $display("FAIL push_overflow got=lat%0d err%b req%0d esp=%h exp=lat2 err1 req0 80", o_lat, o_err, o_req, esp); end
        run_op(OP_CALL, 8'h33, 0, 8'h00);
        checks++; if (o_err !== 1'b1 || eip !== 8'h11) begin failures++; $display("FAIL call_overflow got=err%b eip=%h exp=1 11", o_err, eip); end
    endtask

    task automatic test_accept_inc_and_reset();
        op_valid = 1'b1; op_code = OP_NOP; eip_inc = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; eip_inc = 1'b0;
        checks++; if (eip !== 8'h11 || done !== 1'b1) begin failures++; $display("FAIL nop_with_inc got=%h done=%b exp=11 1", eip, done); end
        @(negedge clk);
        eip_inc = 1'b1;
        @(negedge clk);
        eip_inc = 1'b0;
        checks++; if (eip !== 8'h12) begin failures++; $display("FAIL idle_inc got=%h exp=12", eip); end
        op_valid = 1'b1; op_code = OP_POP;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h80) begin failures++; $display("FAIL pre_reset_mem got=%b %h exp=1 80", mem_req, mem_addr); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL async_reset_req got=%b exp=0", mem_req); end
        checks++; if (esp !== 8'hFF || eip !== 8'h00 || pop_data !== 8'h00 || sel_code !== 4'h3 || op_ready !== 1'b1) begin failures++; $display("FAIL async_reset_regs got=esp%h eip%h pop%h sel%h rdy%b exp=ff 00 00 3 1", esp, eip, pop_data, sel_code, op_ready); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (esp !== 8'hFF || mem_req !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL post_reset got=esp%h req%b done%b exp=ff 0 0", esp, mem_req, done); end
    endtask

    initial begin
        reset_n = 1'b0; op_valid = 1'b0; op_code = 3'd0; op_data = 8'h00;
        eip_inc = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_push();
        test_pop_wait();
        test_call_ret();
        test_enter_leave();
        test_bounds();
        test_accept_inc_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Owns the 8-bit eip, ebp and esp registers of the CPU.
- Sequences multi-cycle stack operations (PUSH, POP, CALL, RET, ENTER, LEAVE) against a single-port data memory.
- Drives the select code consumed by the register-output selector, so the datapath reads esp or immediate at the right time.
- Sits between the instruction decoder (op handshake) and the memory interface.

Parameters:
- STACK_TOP, 8'hFF: reset value of esp and ebp; esp == STACK_TOP means the stack is empty.
- STACK_LIMIT, 8'h80: lowest legal esp; a push with esp == STACK_LIMIT overflows.
- EIP_RESET, 8'h00: reset value of eip.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  decoder presents an operation.
- op_ready  out  1  sequencer accepts an op this cycle.
- op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 ENTER, 6 LEAVE, 7 reserved (treated as NOP).
- op_data  in  8  push data (PUSH) or call target (CALL).
- eip_inc  in  1  sequential fetch advance.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  8  memory address.
- mem_wdata  out  8  write data.
- mem_ack  in  1  access complete; read data valid this cycle.
- mem_rdata  in  8  read data.
- sel_code  out  4  select code to the selector.
- eip  out  8  current eip.
- ebp  out  8  current ebp.
- esp  out  8  current esp.
- pop_data  out  8  value returned by POP.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on overflow/underflow.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - Reset values: eip = EIP_RESET; esp = ebp = STACK_TOP; pop_data = 0; mem_req = mem_we = 0; mem_addr = mem_wdata = 0; done = err = 0; sel_code = 4'h3; state IDLE; op_ready = 1.
  - reset_n falling mid-operation drops mem_req immediately and discards the op; nothing is written back.
- States: IDLE, PREP, MEM, FIN.
- IDLE:
  - op_ready = 1.
  - On op_valid with NOP/reserved: done pulses next cycle, no other effect.
  - On op_valid with any other op: latch op_code/op_data, go to PREP.
  - eip_inc increments eip (mod 256) only in IDLE cycles where no op is accepted.
- PREP (1 cycle):
  - Bounds check first. Overflow: PUSH/CALL/ENTER with esp == STACK_LIMIT. Underflow: POP/RET with esp == STACK_TOP, or LEAVE with ebp == STACK_TOP. On error go to FIN with err set; registers unchanged; no memory access.
  - LEAVE: esp <= ebp in this cycle.
  - Otherwise drive the access and go to MEM:
    - Pushes: mem_addr = esp-1, mem_we = 1. mem_wdata is op_data (PUSH), eip+1 (CALL) or ebp (ENTER).
    - Pops: mem_addr = esp (LEAVE uses the updated esp = ebp), mem_we = 0.
- MEM:
  - mem_req = 1; addr/we/wdata held stable until mem_ack. Ack may arrive in the first MEM cycle.
  - Register updates on the ack edge:
    - PUSH: esp -= 1.
    - CALL: esp -= 1; eip <= op_data.
    - ENTER: esp -= 1; ebp <= esp-1.
    - POP: pop_data <= rdata; esp += 1.
    - RET: eip <= rdata; esp += 1.
    - LEAVE: ebp <= rdata; esp += 1.
  - Then go to FIN.
- FIN: done = 1 (err if flagged) for one cycle, then IDLE.
- sel_code: 4'h2 (esp) in PREP and MEM; 4'h3 (immediate) in IDLE and FIN.
- Latency:
  - Fastest op with zero-wait ack: accept edge T, done high in cycle T+3.
  - Error and NOP paths: done in T+2 and T+1 respectively.
- Arithmetic:
  - All 8-bit unsigned.
  - eip wraps 8'hFF to 8'h00.
  - esp never wraps, because the bounds checks prevent it.
- op_valid while op_ready = 0 is ignored; the decoder must hold it.

Decomposition:
- Shared package cpu_pkg: op_code constants, SEL_ESP = 4'h2, SEL_IMM = 4'h3, state encoding.
- No sub-module; the bounds check is inline.

Test Plan:
- Reset then PUSH op_data = 8'hA5, ack immediate -> mem write addr 8'hFE data 8'hA5; esp = 8'hFE; done at T+3; sel_code = 2 during PREP/MEM.
- PUSH 8'h11, then POP with rdata = 8'h11 and ack after 3 wait cycles -> mem_req held 4 cycles with stable addr 8'hFE; pop_data = 8'h11; esp = 8'hFF.
- eip = 8'h10; CALL op_data = 8'h40 -> write 8'h11 at 8'hFE; eip = 8'h40. Then RET with rdata = 8'h11 -> eip = 8'h11, esp = 8'hFF.
- ENTER then LEAVE from esp = ebp = 8'hFF -> ENTER writes 8'hFF at 8'hFE, ebp = esp = 8'hFE. LEAVE reads 8'hFE, giving ebp = 8'hFF and esp = 8'hFF.
- POP on empty stack -> no mem_req; done and err pulse at T+2; esp stays 8'hFF. Fill to esp = 8'h80, then PUSH -> err, esp stays 8'h80.
- eip_inc asserted in the same cycle an op is accepted -> eip unchanged. Then assert reset_n = 0 during MEM -> mem_req low immediately; all outputs at their reset values.
